// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply engine: default sizes, width
// helpers and the run-state encoding used by the operate-signals FSM.
package matmul_pkg;

  localparam int DEF_DIM    = 3;
  localparam int DEF_DATA_W = 8;

  // Accumulator wide enough for DIM products of two full-scale operands
  function automatic int acc_width(input int dim, input int data_w);
    return 2 * data_w + $clog2(dim);
  endfunction

  function automatic int addr_width(input int dim);
    return $clog2(dim * dim);
  endfunction

  function automatic int idx_width(input int dim);
    return $clog2(dim);
  endfunction

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/matmul_idx_counter.sv
// Nested k/j/i loop counter: k is innermost, i outermost. Wraps fully to zero
// after the last (i,j,k) so the next run starts clean even without a clear.
module matmul_idx_counter #(
  parameter int DIM   = 3,
  parameter int IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_step,
  output logic [IDX_W-1:0] o_i,
  output logic [IDX_W-1:0] o_j,
  output logic [IDX_W-1:0] o_k,
  output logic             o_last_k,
  output logic             o_last_all
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

  logic [IDX_W-1:0] r_i, r_j, r_k;

  // Advance k, carrying into j then i
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_step) begin
      if (r_k != LAST) begin
        r_k <= r_k + 1'b1;
      end else begin
        r_k <= '0;
        if (r_j != LAST) begin
          r_j <= r_j + 1'b1;
        end else begin
          r_j <= '0;
          r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
        end
      end
    end
  end

  assign o_i        = r_i;
  assign o_j        = r_j;
  assign o_k        = r_k;
  assign o_last_k   = (r_k == LAST);
  assign o_last_all = (r_k == LAST) && (r_j == LAST) && (r_i == LAST);

endmodule

// File: rtl/matmul_addr_accum.sv
// Address generation and multiply-accumulate stage of the matrix-multiply
// engine. Steps (i,j,k), drives A/B read addresses and writes each finished
// dot product into C.
module matmul_addr_accum
  import matmul_pkg::*;
#(
  parameter int DIM    = DEF_DIM,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = acc_width(DIM, DATA_W),
  parameter int ADDR_W = addr_width(DIM)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_signalGenAddr,
  input  logic              i_signalAcum,
  input  logic [DATA_W-1:0] i_dataA,
  input  logic [DATA_W-1:0] i_dataB,
  output logic [ADDR_W-1:0] o_addrA,
  output logic [ADDR_W-1:0] o_addrB,
  output logic [ADDR_W-1:0] o_addrC,
  output logic [ACC_W-1:0]  o_dataC,
  output logic              o_weC,
  output logic              o_busy,
  output logic              o_done
);

  localparam int IDX_W = idx_width(DIM);

  logic [0:0]        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [ADDR_W-1:0] r_addr_a, r_addr_b, r_addr_c;
  logic [ACC_W-1:0]  r_data_c;
  logic              r_we_c, r_done;

  logic [IDX_W-1:0]    w_i, w_j, w_k;
  logic                w_last_k, w_last_all;
  logic                w_run, w_gen, w_acum;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_sum;
  logic [ADDR_W-1:0]   w_addr_a, w_addr_b, w_addr_c;

  // A start in RUN takes priority over both strobes in the same cycle
  assign w_run  = (r_state == ST_RUN);
  assign w_gen  = w_run && !i_start && i_signalGenAddr;
  assign w_acum = w_run && !i_start && i_signalAcum;

  assign w_prod   = i_dataA * i_dataB;
  assign w_sum    = (w_k == '0) ? ACC_W'(w_prod) : r_acc + ACC_W'(w_prod);
  assign w_addr_a = ADDR_W'(w_i) * ADDR_W'(DIM) + ADDR_W'(w_k);
  assign w_addr_b = ADDR_W'(w_k) * ADDR_W'(DIM) + ADDR_W'(w_j);
  assign w_addr_c = ADDR_W'(w_i) * ADDR_W'(DIM) + ADDR_W'(w_j);

  matmul_idx_counter #(
    .DIM   (DIM),
    .IDX_W (IDX_W)
  ) u_idx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (i_start),
    .i_step     (w_acum),
    .o_i        (w_i),
    .o_j        (w_j),
    .o_k        (w_k),
    .o_last_k   (w_last_k),
    .o_last_all (w_last_all)
  );

  // Run state, address registers, accumulator and C write port
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_c <= '0;
      r_data_c <= '0;
      r_we_c   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_we_c <= 1'b0;
      r_done <= 1'b0;
      if (i_start) begin
        // Fresh start or restart: partial sum is dropped without a write
        r_state <= ST_RUN;
        r_acc   <= '0;
      end else begin
        if (w_gen) begin
          r_addr_a <= w_addr_a;
          r_addr_b <= w_addr_b;
        end
        if (w_acum) begin
          if (!w_last_k) begin
            r_acc <= w_sum;
          end else begin
            r_data_c <= w_sum;
            r_addr_c <= w_addr_c;
            r_we_c   <= 1'b1;
            r_acc    <= '0;
            if (w_last_all) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
      end
    end
  end

  assign o_addrA = r_addr_a;
  assign o_addrB = r_addr_b;
  assign o_addrC = r_addr_c;
  assign o_dataC = r_data_c;
  assign o_weC   = r_we_c;
  assign o_busy  = w_run;
  assign o_done  = r_done;

endmodule

// File: doc/matmul_addr_accum.md
# matmul_addr_accum

Datapath stage directly downstream of the operate-signals state machine in the matrix-multiply engine. It consumes the `signalGenAddr` and `signalAcum` strobes to step the (i,j,k) loop indices of C = A×B over DIM×DIM matrices. It drives read addresses to the A/B memories and multiply-accumulates the returned operands. On each completed dot product it emits one write of the result into the C memory.

## Interface
- `DIM`, 3: matrix dimension (square, DIM ≥ 2)
- `DATA_W`, 8: unsigned operand width
- `ACC_W`, 2*DATA_W+$clog2(DIM): accumulator/result width, overflow-free
- `ADDR_W`, $clog2(DIM*DIM): memory address width
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: synchronous, active-low reset
- `start` input 1: one-cycle pulse, begins a new multiplication
- `signalGenAddr` input 1: strobe, load addresses for current (i,j,k)
- `signalAcum` input 1: strobe, operands valid, accumulate and advance
- `dataA` input DATA_W: A memory read data
- `dataB` input DATA_W: B memory read data
- `addrA` output ADDR_W: A read address, i*DIM+k
- `addrB` output ADDR_W: B read address, k*DIM+j
- `addrC` output ADDR_W: C write address, i*DIM+j
- `dataC` output ACC_W: C write data
- `weC` output 1: C write enable, one-cycle pulse
- `busy` output 1: multiplication in progress
- `done` output 1: one-cycle pulse on final write

## Operation
- Reset (`rst`=0 at a clock edge) has the following effects:
  - It clears i, j, k, acc, `addrA`, `addrB`, `addrC`, `dataC`, `weC`, `busy` and `done` to 0.
  - It overrides every other input.
  - Reset mid-multiplication abandons the multiplication with no write.
- States:
  - IDLE (`busy`=0). `start` → RUN and clears i, j, k and acc.
  - RUN (`busy`=1). After the write for i=j=k=DIM-1 → IDLE.
- `start` in RUN restarts the multiplication: indices and acc are cleared, and no write is issued for the partial sum. `signalGenAddr` and `signalAcum` arriving in that same cycle are ignored.
- `signalGenAddr` in RUN: `addrA` and `addrB` are registered from the current i, j, k. They hold until the next `signalGenAddr`.
- `signalAcum` in RUN: p = `dataA`*`dataB` (full 2*DATA_W product).
  - If k<DIM-1: acc ← (k==0 ? p : acc+p), then k increments.
  - If k==DIM-1: `dataC` ← (k==0 ? p : acc+p), `addrC` ← i*DIM+j, and `weC`=1 for one cycle. Then acc ← 0 and k ← 0.
  - After that write, j increments. When j wraps, j ← 0 and i increments.
  - If i==j==DIM-1, `done`=1 together with `weC`, and the block returns to IDLE.
- `signalGenAddr` together with `signalAcum` in one cycle: addresses are loaded from the indices before the advance, and the accumulation proceeds normally.
- In IDLE, both strobes are ignored and all registers hold.
- `dataC` and `addrC` hold their last written values between writes.
- Arithmetic is unsigned. ACC_W guarantees no overflow: the maximum sum is DIM*(2^DATA_W-1)^2.

## Timing
- `start` at edge t → `busy`=1 from t+1.
- `signalGenAddr` at t → new `addrA`/`addrB` visible from t+1. The upstream stage waits 4 cycles before `signalAcum`, so memory read latency must be ≤3 cycles.
- `signalAcum` at t with k==DIM-1 → `weC`, `dataC` and `addrC` valid during cycle t+1 only.
- Final `signalAcum` at t → `done`=1 for cycle t+1, and `busy`=0 from t+1.
- One multiplication takes exactly DIM³ `signalAcum` strobes and issues DIM² writes.
- `weC` and `done` are never high for two consecutive cycles.

## Structure
- Shared package `matmul_pkg`:
  - Default DIM and DATA_W.
  - Width functions for ACC_W and ADDR_W.
  - State encoding, shared with the operate-signals state machine.
- Sub-module `matmul_idx_counter`: nested k/j/i counter with a `step` input and `last_k` and `last_all` flags, plus synchronous clear. This block owns the address math, accumulator and write logic.

## Test plan
- DIM=3, A=identity, B=1..9 row-major, full strobe sequence (gen, 4 idle, acum) → 9 writes with addrC 0..8 and dataC 1..9, `done` with the 9th, `busy` low afterwards.
- A=B=all 255, DATA_W=8 → every dataC=195075, no overflow.
- `signalAcum` and `signalGenAddr` pulsed in IDLE → no `weC`, addresses stay 0, `busy` stays 0.
- `start` after 5 acum strobes → no write for the partial sum. A fresh full run gives correct results identical to scenario 1.
- `rst`=0 asserted after 4 writes → all outputs 0 next cycle. A subsequent `start` and full run → correct 9 writes.
- `signalGenAddr` coincident with `signalAcum` at k=1 → addrA and addrB reflect k=1 (pre-advance), and acc is correct.
